// File: rtl/cordic_vec_if.sv
// Vector-in / angle+magnitude-out handshake bundle for the iterative CORDIC vectoring unit.
// The master side is whoever drives vectors in and takes results out.
interface cordic_vec_if;
   logic               in_valid;
   logic               in_ready;
   logic signed [15:0] x_in;
   logic signed [15:0] y_in;
   logic               out_valid;
   logic               out_ready;
   logic signed [15:0] angle_out;
   logic [17:0]        mag_out;
   logic               range_err;

   modport master (
      output in_valid, x_in, y_in, out_ready,
      input  in_ready, out_valid, angle_out, mag_out, range_err
   );

   modport slave (
      input  in_valid, x_in, y_in, out_ready,
      output in_ready, out_valid, angle_out, mag_out, range_err
   );
endinterface

// File: rtl/cordic_vec_iter.sv
// Iterative vectoring-mode CORDIC: returns atan2(y,x) in signed 8.8 degrees and the
// gain-scaled magnitude, running one shared add/shift step per enabled cycle.
module cordic_vec_iter #(
   parameter int ITER = 6,
   parameter int IW   = 18
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        reg_en,
   cordic_vec_if.slave vec_if
);

   typedef enum logic [1:0] {S_IDLE, S_ROT, S_DONE} state_t;

   function automatic logic signed [15:0] atan_lut(input logic [2:0] idx);
      case (idx)
         3'd0:    atan_lut = 16'sh2D00;
         3'd1:    atan_lut = 16'sh1A90;
         3'd2:    atan_lut = 16'sh0E09;
         3'd3:    atan_lut = 16'sh0720;
         3'd4:    atan_lut = 16'sh0393;
         3'd5:    atan_lut = 16'sh01CA;
         default: atan_lut = 16'sh0000;
      endcase
   endfunction

   state_t                r_state;
   logic                  r_in_ready;
   logic                  r_out_valid;
   logic                  r_range_err;
   logic signed [IW-1:0]  r_x;
   logic signed [IW-1:0]  r_y;
   logic signed [15:0]    r_z;
   logic [2:0]            r_i;
   logic signed [15:0]    r_angle;
   logic [17:0]           r_mag;

   logic signed [IW-1:0]  w_x_shr;
   logic signed [IW-1:0]  w_y_shr;
   logic signed [IW-1:0]  w_x_nxt;
   logic signed [IW-1:0]  w_y_nxt;
   logic signed [15:0]    w_z_nxt;
   logic signed [15:0]    w_atan;
   logic                  w_y_neg;
   logic                  w_last;
   logic signed [IW-1:0]  w_x_ext;
   logic signed [IW-1:0]  w_y_ext;

   assign w_x_ext = {{(IW-16){vec_if.x_in[15]}}, vec_if.x_in};
   assign w_y_ext = {{(IW-16){vec_if.y_in[15]}}, vec_if.y_in};

   // Both updates read the pre-iteration x/y; the sign of y picks the rotation direction.
   assign w_x_shr = r_x >>> r_i;
   assign w_y_shr = r_y >>> r_i;
   assign w_y_neg = r_y[IW-1];
   assign w_atan  = atan_lut(r_i);
   assign w_x_nxt = w_y_neg ? (r_x - w_y_shr) : (r_x + w_y_shr);
   assign w_y_nxt = w_y_neg ? (r_y + w_x_shr) : (r_y - w_x_shr);
   assign w_z_nxt = w_y_neg ? (r_z - w_atan)  : (r_z + w_atan);
   assign w_last  = (r_i == 3'(ITER - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_range_err <= 1'b0;
         r_x         <= '0;
         r_y         <= '0;
         r_z         <= '0;
         r_i         <= '0;
         r_angle     <= '0;
         r_mag       <= '0;
      end else if (reg_en) begin
         case (r_state)
            S_IDLE: begin
               if (vec_if.in_valid) begin
                  r_x        <= w_x_ext;
                  r_y        <= w_y_ext;
                  r_z        <= '0;
                  r_i        <= '0;
                  r_in_ready <= 1'b0;
                  // Left half-plane is outside the convergence range: flag it and skip iterating.
                  if (vec_if.x_in[15]) begin
                     r_state     <= S_DONE;
                     r_out_valid <= 1'b1;
                     r_range_err <= 1'b1;
                     r_angle     <= '0;
                     r_mag       <= '0;
                  end else begin
                     r_state <= S_ROT;
                  end
               end
            end
            S_ROT: begin
               r_x <= w_x_nxt;
               r_y <= w_y_nxt;
               r_z <= w_z_nxt;
               r_i <= r_i + 3'd1;
               if (w_last) begin
                  r_angle     <= w_z_nxt;
                  r_mag       <= w_x_nxt[17:0];
                  r_range_err <= 1'b0;
                  r_out_valid <= 1'b1;
                  r_state     <= S_DONE;
               end
            end
            S_DONE: begin
               if (vec_if.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign vec_if.in_ready  = r_in_ready;
   assign vec_if.out_valid = r_out_valid;
   assign vec_if.angle_out = r_angle;
   assign vec_if.mag_out   = r_mag;
   assign vec_if.range_err = r_range_err;

endmodule

// File: tb/tb_cordic_vec_iter.sv
// Directed bench for cordic_vec_iter: hand-iterated CORDIC results, latency, stalls,
// back-pressure, out-of-domain input and mid-operation reset.
module tb_cordic_vec_iter;

   localparam int ITER = 6;

   logic clk = 1'b0;
   logic rst_n;
   logic reg_en;
   int   n_checks = 0;
   int   n_errors = 0;

   cordic_vec_if vif ();

   cordic_vec_iter #(.ITER(ITER), .IW(18)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .reg_en (reg_en),
      .vec_if (vif.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one vector and return once it has been accepted (one edge later).
   task automatic send(input logic signed [15:0] x, input logic signed [15:0] y);
      int guard;
      guard = 0;
      while (!vif.in_ready && guard < 40) begin
         tick();
         guard++;
      end
      if (!vif.in_ready) chk("in_ready_timeout", 0, 1);
      vif.x_in     = x;
      vif.y_in     = y;
      vif.in_valid = 1'b1;
      tick();
      vif.in_valid = 1'b0;
   endtask

   // lat counts edges after the accepting edge until out_valid is seen.
   task automatic wait_out(input int start, output int lat);
      lat = start;
      while (!vif.out_valid && lat < 40) begin
         tick();
         lat++;
      end
      if (!vif.out_valid) chk("out_valid_timeout", 0, 1);
   endtask

   task automatic handoff(input string tag);
      vif.out_ready = 1'b1;
      tick();
      vif.out_ready = 1'b0;
      chk({tag, "_ov_clr"}, int'(vif.out_valid), 0);
      chk({tag, "_rdy_back"}, int'(vif.in_ready), 1);
   endtask

   task automatic run_vec(input string tag, input logic signed [15:0] x, input logic signed [15:0] y,
                          input int e_ang, input int e_mag, input int e_rng, input int e_lat);
      int lat;
      send(x, y);
      wait_out(0, lat);
      chk({tag, "_lat"}, lat, e_lat);
      chk({tag, "_in_rdy"}, int'(vif.in_ready), 0);
      chk({tag, "_ang"}, int'(vif.angle_out), e_ang);
      chk({tag, "_mag"}, int'(vif.mag_out), e_mag);
      chk({tag, "_rng"}, int'(vif.range_err), e_rng);
      handoff(tag);
   endtask

   initial begin
      int lat;
      int seen;
      rst_n         = 1'b0;
      reg_en        = 1'b1;
      vif.in_valid  = 1'b0;
      vif.out_ready = 1'b0;
      vif.x_in      = '0;
      vif.y_in      = '0;
      repeat (3) tick();
      rst_n = 1'b1;

      chk("rst_in_ready", int'(vif.in_ready), 1);
      chk("rst_out_valid", int'(vif.out_valid), 0);
      chk("rst_angle", int'(vif.angle_out), 0);
      chk("rst_mag", int'(vif.mag_out), 0);
      chk("rst_rng", int'(vif.range_err), 0);

      // x=0x4000,y=0 -> angle 0xFF10, mag 26973; then hold it under back-pressure
      send(16'sh4000, 16'sh0000);
      wait_out(0, lat);
      chk("t1_lat", lat, ITER);
      for (int k = 0; k < 10; k++) begin
         chk("hold_ov", int'(vif.out_valid), 1);
         chk("hold_rdy", int'(vif.in_ready), 0);
         chk("hold_ang", int'(vif.angle_out), -240);
         chk("hold_mag", int'(vif.mag_out), 26973);
         chk("hold_rng", int'(vif.range_err), 0);
         tick();
      end
      reg_en        = 1'b0;
      vif.out_ready = 1'b1;
      repeat (2) tick();
      chk("frz_done_ov", int'(vif.out_valid), 1);
      reg_en        = 1'b1;
      vif.out_ready = 1'b0;
      handoff("t1");

      run_vec("t2a", 16'sh2000, 16'sh2000, 11530, 19075, 0, ITER);
      run_vec("t2b", 16'sh2000, -16'sh2000, -11510, 19075, 0, ITER);
      run_vec("t3a", 16'sh0000, 16'sh1000, 23280, 6743, 0, ITER);
      run_vec("t3b", 16'sh7FFF, 16'sh7FFF, 11530, 76300, 0, ITER);
      run_vec("t4", -16'sd5, 16'sd3, 0, 0, 1, 0);

      // reg_en low for 3 cycles after the first iteration stretches latency by 3
      send(16'sh4000, 16'sh0000);
      tick();
      reg_en = 1'b0;
      repeat (3) tick();
      reg_en = 1'b1;
      wait_out(4, lat);
      chk("stall_lat", lat, ITER + 3);
      chk("stall_ang", int'(vif.angle_out), -240);
      chk("stall_mag", int'(vif.mag_out), 26973);
      handoff("stall");

      // Frozen in IDLE: an offered vector is not taken
      reg_en       = 1'b0;
      vif.x_in     = 16'sh1000;
      vif.y_in     = 16'sh0000;
      vif.in_valid = 1'b1;
      repeat (3) tick();
      chk("frz_idle_rdy", int'(vif.in_ready), 1);
      vif.in_valid = 1'b0;
      reg_en       = 1'b1;
      tick();
      chk("frz_idle_rdy2", int'(vif.in_ready), 1);

      // Reset mid-ROT discards the operation
      send(16'sh2000, 16'sh2000);
      repeat (2) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("mrst_in_ready", int'(vif.in_ready), 1);
      chk("mrst_out_valid", int'(vif.out_valid), 0);
      chk("mrst_angle", int'(vif.angle_out), 0);
      chk("mrst_mag", int'(vif.mag_out), 0);
      chk("mrst_rng", int'(vif.range_err), 0);
      seen = 0;
      vif.out_ready = 1'b1;
      for (int k = 0; k < 12; k++) begin
         if (vif.out_valid) seen = 1;
         tick();
      end
      vif.out_ready = 1'b0;
      chk("mrst_no_stale", seen, 0);

      run_vec("post", 16'sh4000, 16'sh0000, -240, 26973, 0, ITER);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
